// File: rtl/usr_pkg.sv
// Shared types and sizing helpers for the universal shift register.
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD = 3'd0,
        USR_SHL  = 3'd1,
        USR_SHR  = 3'd2,
        USR_ROTL = 3'd3,
        USR_ROTR = 3'd4,
        USR_LOAD = 3'd5
    } usr_mode_t;

    // Shift counter width; WIDTH is at least 2, so this is never zero.
    function automatic int usr_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/usr_word_counter.sv
// Counts shifts within a WIDTH-bit word and emits a one-cycle pulse when a word completes.
module usr_word_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        Clk,
    input  logic                        Rst_l,
    input  logic                        Clear,
    input  logic                        Load,
    input  logic                        Step,
    output logic [usr_cnt_w(WIDTH)-1:0] Shift_Cnt,
    output logic                        Word_Valid
);

    localparam int             CW      = usr_cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_p0;
    logic          vld_p0;

    always_ff @(posedge Clk or negedge Rst_l) begin
        if (!Rst_l) begin
            cnt_p0 <= '0;
            vld_p0 <= 1'b0;
        end else if (Clear || Load) begin
            cnt_p0 <= '0;
            vld_p0 <= 1'b0;
        end else if (Step) begin
            // Wrapping at WIDTH-1 keeps non-power-of-2 widths in range.
            if (cnt_p0 == CNT_MAX) begin
                cnt_p0 <= '0;
                vld_p0 <= 1'b1;
            end else begin
                cnt_p0 <= cnt_p0 + 1'b1;
                vld_p0 <= 1'b0;
            end
        end else begin
            vld_p0 <= 1'b0;
        end
    end

    assign Shift_Cnt  = cnt_p0;
    assign Word_Valid = vld_p0;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift, rotate and parallel load, with word-completion tracking.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        Clk,
    input  logic                        Rst_l,
    input  logic                        Clear,
    input  logic [2:0]                  Mode,
    input  logic                        Serial_In_R,
    input  logic                        Serial_In_L,
    input  logic [WIDTH-1:0]            Par_In,
    output logic [WIDTH-1:0]            Par_Out,
    output logic                        Serial_Out_L,
    output logic                        Serial_Out_R,
    output logic [usr_cnt_w(WIDTH)-1:0] Shift_Cnt,
    output logic                        Word_Valid
);

    usr_mode_t        mode;
    logic [WIDTH-1:0] data_p0;
    logic             step;
    logic             load;

    // Codes 6 and 7 have no enum label and fall through to hold.
    assign mode = usr_mode_t'(Mode);
    assign step = (mode == USR_SHL) || (mode == USR_SHR) ||
                  (mode == USR_ROTL) || (mode == USR_ROTR);
    assign load = (mode == USR_LOAD);

    always_ff @(posedge Clk or negedge Rst_l) begin
        if (!Rst_l) begin
            data_p0 <= '0;
        end else if (Clear) begin
            data_p0 <= '0;
        end else begin
            case (mode)
                USR_SHL:  data_p0 <= {data_p0[WIDTH-2:0], Serial_In_R};
                USR_SHR:  data_p0 <= {Serial_In_L, data_p0[WIDTH-1:1]};
                USR_ROTL: data_p0 <= {data_p0[WIDTH-2:0], data_p0[WIDTH-1]};
                USR_ROTR: data_p0 <= {data_p0[0], data_p0[WIDTH-1:1]};
                USR_LOAD: data_p0 <= Par_In;
                default:  data_p0 <= data_p0;
            endcase
        end
    end

    usr_word_counter #(
        .WIDTH (WIDTH)
    ) u_word_counter (
        .Clk        (Clk),
        .Rst_l      (Rst_l),
        .Clear      (Clear),
        .Load       (load),
        .Step       (step),
        .Shift_Cnt  (Shift_Cnt),
        .Word_Valid (Word_Valid)
    );

    assign Par_Out      = data_p0;
    assign Serial_Out_L = data_p0[WIDTH-1];
    assign Serial_Out_R = data_p0[0];

endmodule
